linear_layer_start_fifo_ctrl: RTL

Control and read-side wrapper for the SRL-based start FIFOs between the Linear_Layer_i4xi4_q dataflow processes. The producer process writes start tokens. The consumer process (for example a PE_i4xi4_pack instance) reads them through a show-ahead port. The block owns the shift-register storage, the read-address pointer, the occupancy count and the full/empty flags. It presents the HLS FIFO handshake on both ends.

---
 rtl/linear_layer_start_fifo_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start-token FIFO for the linear-layer dataflow: shift-register storage,
// show-ahead read port, occupancy count and registered full/empty flags.
module linear_layer_start_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   num_data_valid,
    output logic [ADDR_WIDTH:0]   fifo_cap
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] raddr;

    // Reset gates push so storage never shifts while tokens are discarded.
    assign push = if_write & if_write_ce & full_n_q & ~reset;
    assign pop  = if_read & if_read_ce & empty_n_q;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
            mem_d[0] = if_din;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_n_d  = (cnt_d != DEPTH_C);
        empty_n_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    // Oldest token sits at entry cnt-1; empty falls back to entry 0.
    assign raddr = (cnt_q != '0) ? ADDR_WIDTH'(cnt_q - CW'(1)) : '0;

    assign if_dout        = mem_q[raddr];
    assign if_full_n      = full_n_q;
    assign if_empty_n     = empty_n_q;
    assign num_data_valid = cnt_q;
    assign fifo_cap       = DEPTH_C;

endmodule
